tcm_mp: RTL and testbench
=========================

Name: tcm_mp

Overview:
Parametrised multi-port tightly coupled memory, the successor to the single-array DTCM. It serves NUM_PORTS requesters (core data, AXI slave, DMA, ...), with one array access per cycle. Access goes through a registered (p-type) read path with a fixed one-cycle read latency, per-port ready/valid handshakes, and byte-strobed writes. It sits beside the core as the data TCM and is instanced with different DEPTH/NUM_PORTS for ITCM/DTCM.

Parameters:
NUM_PORTS, 3, number of requester ports; port 0 has highest fixed priority (valid range 1..8)
DATA_WIDTH, 32, word width in bits; multiple of 8
ADDR_WIDTH, 32, byte address width per port
DEPTH, 8192, words in array; power of two
STRB_WIDTH, DATA_WIDTH/8, byte strobe width (derived; not to be overridden)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous reset, active low
req_access  input  NUM_PORTS  per-port access request
req_rd0_wr1  input  NUM_PORTS  per-port command, rd=0, wr=1
req_byte_strobe  input  NUM_PORTS*STRB_WIDTH  per-port write strobes; port p at [p*STRB_WIDTH +: STRB_WIDTH]
req_addr  input  NUM_PORTS*ADDR_WIDTH  per-port byte address, packed the same way
req_wdata  input  NUM_PORTS*DATA_WIDTH  per-port write data, packed the same way
req_ready  output  NUM_PORTS  one-hot grant; access accepted this cycle
rdata  output  DATA_WIDTH  registered read data, shared by all ports
rdata_valid  output  NUM_PORTS  one-hot; rdata belongs to this port
busy  output  1  an access is accepted this cycle (OR of req_ready)

Behaviour:
- Reset is asynchronous and active low (rstn). During reset: rdata=0, rdata_valid=0, arbiter pointer=0. Array contents are not reset.
- Clocking: single clock domain, clk.
- Arbitration (combinational, every cycle): grant goes to the lowest-indexed port with req_access=1. req_ready is one-hot or zero. Exactly one access per cycle.
- Handshake: a requester holds access/cmd/addr/wdata/strobe stable until it sees req_ready=1 in the same cycle. The transfer completes on that edge. Deasserting before the grant is allowed (request withdrawn, no side effects).
- Word index: addr[OFS+IDX-1:OFS], where OFS=log2(STRB_WIDTH) and IDX=log2(DEPTH). Upper address bits are ignored (aliasing). Low OFS bits are ignored.
- Write: on a granted write, each byte lane i with strobe[i]=1 is updated at the clk edge; other lanes are unchanged. Strobe=0 gives a legal no-op write. No rdata_valid is generated.
- Read: on a granted read in cycle N, rdata is loaded with the array word at edge N, and rdata_valid[granted port]=1 during cycle N+1 only. Back-to-back reads from any mix of ports give valid on consecutive cycles.
- rdata holds its last value when no read completes; rdata_valid returns to 0.
- Read-after-write: a write granted in cycle N followed by a read of the same word in cycle N+1 returns the new data. There is no same-cycle conflict, since only one access is granted per cycle.
- Starvation: with fixed priority, continuous port 0 traffic blocks the others. This is accepted unless TCM_RR_ARB_EN is defined.
- Reset asserted mid-operation: any pending rdata_valid is cleared immediately. A write occurring on the same edge as reset assertion is not guaranteed.
- Multi-bit X on req_access is not a supported input.

Optional Feature:
TCM_RR_ARB_EN.
- Defined: round-robin arbitration. A NUM_PORTS-bit one-hot pointer (reset value 1) marks the highest-priority port. The search runs pointer, pointer+1, ..., wrapping. After any grant to port g, the pointer moves to g+1 mod NUM_PORTS; with no grant it holds.
- Not defined: fixed priority as above; pointer logic is absent.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then single write/read: port 0 writes 0xDEADBEEF at addr 0x10 with strobe 0xF, then reads 0x10 → req_ready[0]=1 each cycle; rdata=0xDEADBEEF and rdata_valid=3'b001 one cycle after the read grant.
- Byte strobes: word holds 0x11223344, write 0xAABBCCDD with strobe 0x5 → read returns 0x11BB33DD.
- Contention (fixed priority): ports 0, 1 and 2 all request reads in the same cycle → grants 001, 010, 100 over three consecutive cycles (port 0 drops after its grant); rdata_valid follows one cycle later with the matching data.
- RR build: all three ports keep requesting continuously for 6 cycles → grants 001, 010, 100, 001, 010, 100.
- Read-after-write and aliasing (DEPTH=8192): write 0x5A5A5A5A at 0x0000_0004, then next cycle read 0x0000_8004 → returns 0x5A5A5A5A.
- Mid-read reset: assert rstn=0 in the cycle after a read grant → rdata_valid=0 and rdata=0 immediately; after release, no stale valid.

Source files
------------

// File: rtl/tcm_mp.sv
// ---------------------------------------------------------------------------
// tcm_mp : multi-port tightly coupled memory
//
// One word-wide array shared by NUM_PORTS requesters. Each cycle at most one
// request is granted; the granted access hits the array on the clock edge.
// Reads return on the shared rdata bus one cycle later, tagged by a one-hot
// rdata_valid. Writes use byte strobes and return nothing.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   req_access         per-port request
//   req_rd0_wr1        per-port command (0 = read, 1 = write)
//   req_byte_strobe    per-port byte lanes, port p at [p*STRB_WIDTH +: STRB_WIDTH]
//   req_addr           per-port byte address, packed like the strobes
//   req_wdata          per-port write data, packed like the strobes
//   req_ready          one-hot grant for this cycle
//   rdata              registered read data
//   rdata_valid        one-hot owner of rdata for this cycle
//   busy               some access is granted this cycle
//
// Build option:
//   TCM_RR_ARB_EN      when defined, round-robin arbitration replaces the
//                      fixed port-0-first priority.
// ---------------------------------------------------------------------------
module tcm_mp #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8192,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_PORTS-1:0]             req_access,
  input  logic [NUM_PORTS-1:0]             req_rd0_wr1,
  input  logic [NUM_PORTS*STRB_WIDTH-1:0]  req_byte_strobe,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [NUM_PORTS-1:0]             rdata_valid,
  output logic                             busy
);

  localparam int OFS = $clog2(STRB_WIDTH);
  localparam int IDX = $clog2(DEPTH);

  logic [NUM_PORTS-1:0]  grant;
  logic                  sel_wr;
  logic [STRB_WIDTH-1:0] sel_strb;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [IDX-1:0]        widx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] unused_addr_bits;

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]  rdata_valid_q, rdata_valid_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef TCM_RR_ARB_EN
  logic [NUM_PORTS-1:0] ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] req_hi;

  // Requests at or above the pointer are tried first; x & -x isolates the
  // lowest set bit, so the lowest such port wins. If none exist the search
  // wraps to the lowest requesting port overall.
  always_comb begin
    req_hi = req_access & ~(ptr_q - NUM_PORTS'(1));
    if (req_hi != '0) begin
      grant = req_hi & (~req_hi + NUM_PORTS'(1));
    end else begin
      grant = req_access & (~req_access + NUM_PORTS'(1));
    end
    ptr_d = ptr_q;
    if (grant != '0) begin
      ptr_d = (grant << 1) | (grant >> (NUM_PORTS - 1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= NUM_PORTS'(1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest-indexed requester, via the lowest-set-bit trick.
  always_comb begin
    grant = req_access & (~req_access + NUM_PORTS'(1));
  end
`endif

  // Steer the granted port's command onto the single array port.
  always_comb begin
    sel_wr    = 1'b0;
    sel_strb  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_wr    = req_rd0_wr1[p];
        sel_strb  = req_byte_strobe[p*STRB_WIDTH +: STRB_WIDTH];
        sel_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Byte offset and upper address bits do not select a word; upper bits alias.
  assign widx             = sel_addr[OFS+IDX-1:OFS];
  assign unused_addr_bits = sel_addr;
  assign rd_word          = mem[widx];

  // Strobed lanes take new data, the rest keep the stored bytes.
  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (sel_strb[b]) begin
        wr_word[b*8 +: 8] = sel_wdata[b*8 +: 8];
      end
    end
  end

  assign wr_en = busy & sel_wr;

  // The array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[widx] <= wr_word;
    end
  end

  // rdata only moves on a granted read; otherwise it keeps its last word.
  always_comb begin
    rdata_d       = rdata_q;
    rdata_valid_d = '0;
    if (busy && !sel_wr) begin
      rdata_d       = rd_word;
      rdata_valid_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q       <= '0;
      rdata_valid_q <= '0;
    end else begin
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign req_ready   = grant;
  assign busy        = |grant;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_tcm_mp.sv
// ---------------------------------------------------------------------------
// tb_tcm_mp : self-checking bench for tcm_mp (default parameters)
//
// Requesters are modelled as per-port pending commands that stay on the bus
// until granted. A reference model (word memory keyed by word index, search
// order arbitration, one-cycle read return) predicts req_ready/busy before
// each edge and rdata/rdata_valid after it. Honours TCM_RR_ARB_EN.
// ---------------------------------------------------------------------------
module tb_tcm_mp;

  localparam int NP = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NP-1:0] req_access;
  logic [NP-1:0] req_rd0_wr1;
  logic [NP*4-1:0]  req_byte_strobe;
  logic [NP*32-1:0] req_addr;
  logic [NP*32-1:0] req_wdata;
  logic [NP-1:0] req_ready;
  logic [31:0]   rdata;
  logic [NP-1:0] rdata_valid;
  logic          busy;

  tcm_mp dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_access      (req_access),
    .req_rd0_wr1     (req_rd0_wr1),
    .req_byte_strobe (req_byte_strobe),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rdata           (rdata),
    .rdata_valid     (rdata_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Pending requester commands
  bit          p_acc   [NP];
  bit          p_wr    [NP];
  logic [3:0]  p_strb  [NP];
  logic [31:0] p_addr  [NP];
  logic [31:0] p_wdata [NP];
  bit          p_sticky;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata;
  logic [31:0] m_valid;
  int          m_ptr;

  int vectors;
  int miscompares;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < NP; p++) begin
      req_access[p]           = p_acc[p];
      req_rd0_wr1[p]          = p_wr[p];
      req_byte_strobe[p*4 +: 4] = p_strb[p];
      req_addr[p*32 +: 32]    = p_addr[p];
      req_wdata[p*32 +: 32]   = p_wdata[p];
    end
  endtask

  task automatic setReq(input int p, input bit wr, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata);
    p_acc[p]   = 1'b1;
    p_wr[p]    = wr;
    p_strb[p]  = strb;
    p_addr[p]  = addr;
    p_wdata[p] = wdata;
  endtask

  function automatic int modelGrant();
    int start;
    int q;
`ifdef TCM_RR_ARB_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NP; k++) begin
      q = (start + k) % NP;
      if (p_acc[q]) return q;
    end
    return -1;
  endfunction

  // Word index = byte address / 4, modulo 8192 words.
  function automatic int wordOf(input logic [31:0] addr);
    return int'((addr >> 2) % 32'd8192);
  endfunction

  // Called just after a rising edge: drive, check grant mid-cycle, step the
  // model on the edge, then check the registered outputs.
  task automatic runCycle(input string tag);
    int g;
    int w;
    logic [31:0] word;
    logic [31:0] exp_ready;
    applyStimulus();
    #4;
    g = modelGrant();
    exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
    checkOutput({tag, "/req_ready"}, 32'(req_ready), exp_ready);
    checkOutput({tag, "/busy"}, 32'(busy), (g >= 0) ? 32'd1 : 32'd0);
    @(posedge clk);
    m_valid = 32'd0;
    if (g >= 0) begin
      w = wordOf(p_addr[g]);
      if (p_wr[g]) begin
        word = m_mem.exists(w) ? m_mem[w] : 32'hx;
        for (int b = 0; b < 4; b++) begin
          if (p_strb[g][b]) word[b*8 +: 8] = p_wdata[g][b*8 +: 8];
        end
        m_mem[w] = word;
      end else begin
        m_rdata = m_mem.exists(w) ? m_mem[w] : 32'hx;
        m_valid = 32'd1 << g;
      end
      m_ptr = (g + 1) % NP;
      if (!p_sticky) p_acc[g] = 1'b0;
    end
    #1;
    checkOutput({tag, "/rdata_valid"}, 32'(rdata_valid), m_valid);
    checkOutput({tag, "/rdata"}, rdata, m_rdata);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((p_acc[0] || p_acc[1] || p_acc[2]) && n < budget) begin
      runCycle(tag);
      n++;
    end
    checkOutput({tag, "/drain_timeout"}, 32'(p_acc[0] || p_acc[1] || p_acc[2]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    p_sticky    = 1'b0;
    for (int p = 0; p < NP; p++) begin
      p_acc[p] = 1'b0; p_wr[p] = 1'b0; p_strb[p] = 4'h0;
      p_addr[p] = 32'h0; p_wdata[p] = 32'h0;
    end
    m_rdata = 32'h0;
    m_valid = 32'h0;
    m_ptr   = 0;
    applyStimulus();

    // Reset state
    #12;
    checkOutput("reset/rdata", rdata, 32'h0);
    checkOutput("reset/rdata_valid", 32'(rdata_valid), 32'h0);
    checkOutput("reset/req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Single write then read on port 0
    setReq(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    runCycle("wr0");
    setReq(0, 1'b0, 4'h0, 32'h10, 32'h0);
    runCycle("rd0");
    checkOutput("rd0/const_data", rdata, 32'hDEADBEEF);
    checkOutput("rd0/const_valid", 32'(rdata_valid), 32'h1);
    runCycle("idle_hold");

    // Byte strobes
    setReq(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
    runCycle("strb_init");
    setReq(0, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD);
    runCycle("strb_wr");
    setReq(0, 1'b0, 4'h0, 32'h20, 32'h0);
    runCycle("strb_rd");
    checkOutput("strb/const_data", rdata, 32'h11BB33DD);

    // Three-way read contention
    setReq(0, 1'b1, 4'hF, 32'h30, 32'h0BADF00D);
    runCycle("cont_init");
    setReq(0, 1'b0, 4'h0, 32'h30, 32'h0);
    setReq(1, 1'b0, 4'h0, 32'h10, 32'h0);
    setReq(2, 1'b0, 4'h0, 32'h20, 32'h0);
    drain("contention", 6);

    // All ports requesting continuously for 6 cycles
    p_sticky = 1'b1;
    setReq(0, 1'b0, 4'h0, 32'h30, 32'h0);
    setReq(1, 1'b0, 4'h0, 32'h10, 32'h0);
    setReq(2, 1'b0, 4'h0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) runCycle("continuous");
    p_sticky = 1'b0;
    for (int p = 0; p < NP; p++) p_acc[p] = 1'b0;

    // Read-after-write with upper-address aliasing
    setReq(1, 1'b1, 4'hF, 32'h0000_0004, 32'h5A5A5A5A);
    runCycle("raw_wr");
    setReq(2, 1'b0, 4'h0, 32'h0000_8004, 32'h0);
    runCycle("raw_rd");
    checkOutput("raw/const_data", rdata, 32'h5A5A5A5A);
    checkOutput("raw/const_valid", 32'(rdata_valid), 32'h4);

    // Reset asserted in the cycle after a read grant
    setReq(0, 1'b0, 4'h0, 32'h10, 32'h0);
    runCycle("midrst_rd");
    rstn = 1'b0;
    m_rdata = 32'h0;
    m_valid = 32'h0;
    m_ptr   = 0;
    #1;
    checkOutput("midrst/rdata", rdata, 32'h0);
    checkOutput("midrst/rdata_valid", 32'(rdata_valid), 32'h0);
    for (int p = 0; p < NP; p++) p_acc[p] = 1'b0;
    applyStimulus();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    runCycle("post_rst");
    runCycle("post_rst");

    // Randomised traffic over words 0..15 with aliasing, withdrawals
    for (int i = 0; i < 16; i++) begin
      setReq(i % NP, 1'b1, 4'hF, 32'(i * 4), $urandom);
      drain("rand_init", 8);
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!p_acc[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            setReq(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   (32'($urandom_range(0, 7)) << 15) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3)),
                   $urandom);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          p_acc[p] = 1'b0;
        end
      end
      runCycle("rand");
    end
    drain("rand_drain", 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
